// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
// Pointer type and wrap helper for the 3-entry output buffer.
package fifo_pkg;

  localparam int DATA_WIDTH   = 8;
  localparam int RD_BUF_DEPTH = 3;

  typedef logic [1:0] ptr_t;

  function automatic ptr_t ptr_wrap_inc(input ptr_t p);
    return (p == ptr_t'(RD_BUF_DEPTH - 1)) ? ptr_t'(0) : p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// Consumer-side valid/ready stream of the FIFO read adapter.
// master drives the stream, slave is the consumer.
interface fifo_rd_stream_if
  import fifo_pkg::*;
#(
  parameter int W = DATA_WIDTH
);

  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic [1:0]   level;

  modport master (
    output out_valid,
    output out_data,
    output level,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  level,
    output out_ready
  );

endinterface

// File: rtl/rd_skid_buffer.sv
// 3-entry circular buffer with pointers, count and flush.
// Storage is not reset; only pointers and count are.
module rd_skid_buffer
  import fifo_pkg::*;
#(
  parameter int W = DATA_WIDTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic [1:0]   cnt
);

  logic [W-1:0] mem_q [RD_BUF_DEPTH];
  ptr_t         wp_q, wp_d;
  ptr_t         rp_q, rp_d;
  logic [1:0]   cnt_q, cnt_d;

  // Next pointers and count; flush wins over push and pop.
  always_comb begin
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = ptr_wrap_inc(wp_q);
      if (pop)  rp_d = ptr_wrap_inc(rp_q);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + 2'd1;
        2'b01:   cnt_d = cnt_q - 2'd1;
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // Word storage; a capture landing on a flush edge is dropped.
  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wp_q] <= din;
  end

  assign dout = mem_q[rp_q];
  assign cnt  = cnt_q;

endmodule

// File: rtl/fifo_rd_stream.sv
// Read-side adapter: FIFO read port to first-word-fall-through stream.
// Issues reads only from registered state, so no out_ready->rinc path.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = fifo_pkg::DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  empty,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  rinc,
  input  logic                  flush,
  fifo_rd_stream_if.master      s
);

  logic                  inflight_q, inflight_d;
  logic [2:0]            occ;
  logic [1:0]            cnt;
  logic                  pop;
  logic [DATA_WIDTH-1:0] dout;

  // Read request: room must exist for the word already in flight.
  always_comb begin
    occ        = {1'b0, cnt} + {2'b00, inflight_q};
    rinc       = ~empty & ~flush & ~rst
               & (occ < 3'(RD_BUF_DEPTH));
    inflight_d = rinc;
  end

  // A read issued this cycle returns data next cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) inflight_q <= 1'b0;
    else     inflight_q <= inflight_d;
  end

  assign s.out_valid = (cnt != 2'd0) & ~flush;
  assign s.out_data  = dout;
  assign s.level     = cnt;
  assign pop         = s.out_valid & s.out_ready;

  rd_skid_buffer #(
    .W (DATA_WIDTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (inflight_q),
    .din   (rdata),
    .pop   (pop),
    .dout  (dout),
    .cnt   (cnt)
  );

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: FIFO model,
// scoreboard queue of read words, monitor on the stream side.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       empty;
  logic       empty_force = 1'b0;
  logic [7:0] rdata = '0;
  logic       rinc;
  logic       flush = 1'b0;

  fifo_rd_stream_if #(.W(8)) s_if ();

  fifo_rd_stream #(.DATA_WIDTH(8)) dut (
    .clk   (clk),
    .rst   (rst),
    .empty (empty),
    .rdata (rdata),
    .rinc  (rinc),
    .flush (flush),
    .s     (s_if)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [7:0] mem [0:4095];
  int         wr_idx = 0;
  int         rd_idx = 0;
  logic [7:0] exp_q [$];
  bit         infl_m = 1'b0;

  assign empty = empty_force | (rd_idx == wr_idx);

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, req, $time);
    end
  endtask

  // FIFO model: a granted read returns its word next cycle.
  // Words read are expected on the stream unless flushed/reset.
  always @(posedge clk or posedge rst) begin
    if (rst || flush) begin
      exp_q.delete();
      infl_m <= 1'b0;
    end else begin
      infl_m <= rinc && !empty;
      if (rinc && !empty) begin
        exp_q.push_back(mem[rd_idx]);
        rdata  <= mem[rd_idx];
        rd_idx <= rd_idx + 1;
      end
    end
  end

  // Monitor: compare stream against scoreboard mid-cycle.
  always @(negedge clk) begin
    int lvl;
    bit vexp;
    bit rexp;
    lvl  = exp_q.size() - int'(infl_m);
    vexp = (lvl != 0) && !flush && !rst;
    rexp = !empty && !flush && !rst && (lvl + int'(infl_m) < 3);
    chk("level", 32'(s_if.level), 32'(lvl));
    chk("out_valid", 32'(s_if.out_valid), 32'(vexp));
    chk("rinc", 32'(rinc), 32'(rexp));
    if (empty) chk("read_while_empty", 32'(rinc), 0);
    if (s_if.out_valid && s_if.out_ready) begin
      if (exp_q.size() > int'(infl_m)) begin
        chk("out_data", 32'(s_if.out_data), 32'(exp_q[0]));
        void'(exp_q.pop_front());
      end else begin
        chk("unexpected_word", 32'(s_if.out_data), 32'hFFFF_FFFF);
      end
    end
  end

  task automatic load(input int n, input bit rnd,
                      input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      mem[wr_idx] = rnd ? 8'($urandom) : base + 8'(i);
      wr_idx++;
    end
  endtask

  task automatic drain(input int budget);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || s_if.level != 0 ||
            rd_idx != wr_idx) && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("drain_in_budget", 32'(k < budget), 1);
  endtask

  task automatic wait_level(input logic [1:0] l, input int budget);
    int k;
    k = 0;
    while (s_if.level != l && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    chk("reach_level", 32'(s_if.level), 32'(l));
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    s_if.out_ready = 1'b1;
    @(negedge clk);
    chk("rst_level", 32'(s_if.level), 0);
    chk("rst_valid", 32'(s_if.out_valid), 0);
    chk("rst_rinc", 32'(rinc), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // streaming
    load(16, 1'b0, 8'h01);
    drain(100);

    // back-pressure
    s_if.out_ready = 1'b0;
    load(5, 1'b0, 8'h01);
    repeat (8) begin
      @(posedge clk); #1;
    end
    chk("bp_level", 32'(s_if.level), 3);
    chk("bp_rinc", 32'(rinc), 0);
    chk("bp_data", 32'(s_if.out_data), 32'h01);
    @(posedge clk); #1;
    chk("bp_data_hold", 32'(s_if.out_data), 32'h01);
    s_if.out_ready = 1'b1;
    drain(50);

    // random ready
    load(200, 1'b1, 8'h00);
    for (int k = 0; k < 3000; k++) begin
      if (rd_idx == wr_idx && exp_q.size() == 0) break;
      @(posedge clk); #1;
      s_if.out_ready = 1'($urandom_range(0, 1));
    end
    s_if.out_ready = 1'b1;
    drain(50);

    // flush with data in flight
    s_if.out_ready = 1'b0;
    load(5, 1'b0, 8'hA1);
    wait_level(2'd2, 20);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    chk("flush_level", 32'(s_if.level), 0);
    chk("flush_valid", 32'(s_if.out_valid), 0);
    s_if.out_ready = 1'b1;
    drain(50);

    // reset mid-stream
    s_if.out_ready = 1'b0;
    load(8, 1'b0, 8'h06);
    wait_level(2'd3, 20);
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(s_if.out_valid), 0);
    chk("arst_rinc", 32'(rinc), 0);
    chk("arst_level", 32'(s_if.level), 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
    s_if.out_ready = 1'b1;
    drain(50);

    // empty toggling
    load(20, 1'b1, 8'h00);
    for (int k = 0; k < 80; k++) begin
      @(posedge clk); #1;
      empty_force = ~empty_force;
    end
    empty_force = 1'b0;
    drain(50);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
